// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - request/response channel and APB bus bundle for apb_master_bridge
interface apb_master_bridge_if #(
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [31:0]   PWDATA;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  // bridge side: drives the APB bus and the response channel
  modport master (
    input  req_valid, req_addr, req_write, req_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB initiator with valid/ready request and response channels
module apb_master_bridge #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 256,
  parameter int CW      = 9
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  apb_master_bridge_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam bit            TO_EN     = (TIMEOUT != 0);
  localparam logic [CW-1:0] LAST_WAIT = TO_EN ? CW'(TIMEOUT - 1) : '0;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          accept;
  logic          complete;
  logic          abort;

  assign accept   = bus.req_valid & bus.req_ready;
  assign complete = (state == ACCESS) & bus.PREADY;
  // a ready slave on the timeout edge still completes normally
  assign abort    = TO_EN & (state == ACCESS) & ~bus.PREADY & (wait_cnt == LAST_WAIT);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (complete || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.PSEL      = (state != IDLE);
    bus.PENABLE   = (state == ACCESS);
    bus.req_ready = (state == IDLE) & ~bus.rsp_valid;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bus.PADDR       <= '0;
      bus.PWRITE      <= 1'b0;
      bus.PWDATA      <= '0;
      wait_cnt        <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      // address/data stay at their last values after the transfer ends
      if (accept) begin
        bus.PADDR  <= bus.req_addr;
        bus.PWRITE <= bus.req_write;
        bus.PWDATA <= bus.req_wdata;
        wait_cnt   <= '0;
      end else if ((state == ACCESS) && !bus.PREADY) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (complete) begin
        bus.rsp_valid   <= 1'b1;
        bus.rsp_rdata   <= bus.PWRITE ? 32'h0 : bus.PRDATA;
        bus.rsp_err     <= bus.PSLVERR;
        bus.rsp_timeout <= 1'b0;
      end else if (abort) begin
        bus.rsp_valid   <= 1'b1;
        bus.rsp_rdata   <= 32'h0;
        bus.rsp_err     <= 1'b1;
        bus.rsp_timeout <= 1'b1;
      end else if (bus.rsp_valid && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed table-driven bench for apb_master_bridge
module tb_apb_master_bridge;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  apb_master_bridge_if #(.AW(32)) bus ();

  apb_master_bridge #(.AW(32), .TIMEOUT(4), .CW(9)) dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_access;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // drives one request and plays the APB slave; waits >= 4 never raises PREADY
  task automatic run_vec(input vec_t v, input string tag);
    int acc;
    bit done;
    bus.req_valid = 1'b1;
    bus.req_write = v.write;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    cyc();
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hFFFF_FFF0;
    bus.req_wdata = 32'h0BAD_0BAD;
    bus.req_write = ~v.write;
    chk({tag, "_setup_psel"}, 32'(bus.PSEL), 32'd1);
    chk({tag, "_setup_penable"}, 32'(bus.PENABLE), 32'd0);
    chk({tag, "_setup_paddr"}, bus.PADDR, v.addr);
    chk({tag, "_setup_pwrite"}, 32'(bus.PWRITE), 32'(v.write));
    chk({tag, "_setup_pwdata"}, bus.PWDATA, v.wdata);
    cyc();
    acc  = 0;
    done = 1'b0;
    while (!done && acc < 16) begin
      chk({tag, "_acc_penable"}, 32'(bus.PENABLE), 32'd1);
      chk({tag, "_acc_paddr"}, bus.PADDR, v.addr);
      if (acc < v.waits) begin
        bus.PREADY  = 1'b0;
        bus.PRDATA  = 32'hDEAD_BEEF;
        bus.PSLVERR = 1'b1;
      end else begin
        bus.PREADY  = 1'b1;
        bus.PRDATA  = v.prdata;
        bus.PSLVERR = v.slverr;
      end
      cyc();
      acc++;
      if (!bus.PSEL) done = 1'b1;
    end
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = 32'h0;
    chk({tag, "_access_cycles"}, 32'(acc), 32'(v.exp_access));
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, v.exp_rdata);
    chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    chk({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'(v.exp_to));
    chk({tag, "_end_penable"}, 32'(bus.PENABLE), 32'd0);
    chk({tag, "_end_paddr_held"}, bus.PADDR, v.addr);
    chk({tag, "_end_pwdata_held"}, bus.PWDATA, v.wdata);
    chk({tag, "_busy_req_ready"}, 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;
    chk({tag, "_consumed"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rdata_hold"}, bus.rsp_rdata, v.exp_rdata);
    chk({tag, "_ready_again"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    //             wr    addr          wdata         waits prdata        err   exp_rdata     eerr  eto   acc
    vecs[0] = '{1'b1, 32'h0000_0004, 32'h0000_00FF, 0, 32'h55AA_55AA, 1'b0, 32'h0,         1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 32'h0000_0200, 32'h0,         3, 32'h0000_0005, 1'b0, 32'h0000_0005, 1'b0, 1'b0, 4};
    vecs[2] = '{1'b0, 32'h0000_0300, 32'h0,         0, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1};
    vecs[3] = '{1'b0, 32'h0000_0040, 32'h0,         4, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 4};
    vecs[4] = '{1'b0, 32'h0000_0044, 32'h0,         3, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 4};
    vecs[5] = '{1'b1, 32'h0000_0008, 32'h0000_A5A5, 2, 32'h7777_7777, 1'b1, 32'h0,         1'b1, 1'b0, 3};

    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_write = 1'b0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = 32'h0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_psel", 32'(bus.PSEL), 32'd0);
    chk("rst_penable", 32'(bus.PENABLE), 32'd0);
    chk("rst_pwrite", 32'(bus.PWRITE), 32'd0);
    chk("rst_paddr", bus.PADDR, 32'h0);
    chk("rst_pwdata", bus.PWDATA, 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // backpressure: response held, a second request waits until it is consumed
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h0000_0011;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_0010;
    cyc();
    bus.req_addr = 32'h0000_0020;
    cyc();
    cyc();
    chk("bp_first_rsp", 32'(bus.rsp_valid), 32'd1);
    chk("bp_first_rdata", bus.rsp_rdata, 32'h0000_0011);
    for (int k = 0; k < 5; k++) begin
      chk("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
      chk("bp_psel_low", 32'(bus.PSEL), 32'd0);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;
    chk("bp_req_ready_back", 32'(bus.req_ready), 32'd1);
    cyc();
    bus.req_valid = 1'b0;
    chk("bp_second_setup", 32'(bus.PSEL & ~bus.PENABLE), 32'd1);
    chk("bp_second_paddr", bus.PADDR, 32'h0000_0020);
    bus.PRDATA = 32'h0000_0022;
    cyc();
    cyc();
    chk("bp_second_rdata", bus.rsp_rdata, 32'h0000_0022);
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
    chk("bp_second_consumed", 32'(bus.rsp_valid), 32'd0);

    // reset during an ACCESS wait state drops the transfer without a response
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0500;
    cyc();
    bus.req_valid = 1'b0;
    cyc();
    cyc();
    chk("mid_in_access", 32'(bus.PENABLE), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_psel", 32'(bus.PSEL), 32'd0);
    chk("mid_rst_penable", 32'(bus.PENABLE), 32'd0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_paddr", bus.PADDR, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
    run_vec(vecs[2], "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
